// File: rtl/adc_axil_read_ctrl.sv
// -----------------------------------------------------------------------------
// adc_axil_read_ctrl
//
// AXI4-Lite read-channel slave for the ADC IP register banks. It accepts one
// AR request at a time and checks it against the [C_BASEADDR, C_HIGHADDR]
// window. A valid address gets one read strobe (rd_en/rd_idx) to the register
// file, and rd_data is captured RD_LATENCY cycles later. The block answers with
// OKAY, SLVERR (unaligned address or index past NUM_REGS) or DECERR (address
// outside the window).
//
// Ports
//   ACLK, ARESET          clock; asynchronous active-high reset
//   ARADDR/ARVALID/ARREADY AXI4-Lite read address channel
//   RDATA/RRESP/RVALID/RREADY AXI4-Lite read data channel
//   rd_en, rd_idx         one-cycle read strobe and register index to the
//                         register file (rd_idx holds until the next strobe)
//   rd_data               register file read data
//   rd_err                one-cycle pulse in the first cycle of an error response
// -----------------------------------------------------------------------------
module adc_axil_read_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] C_BASEADDR = '0,
  parameter logic [ADDR_W-1:0] C_HIGHADDR = ADDR_W'(32'h0000_0FFF),
  parameter int                NUM_REGS   = 8,
  parameter int                RD_LATENCY = 0,
  localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam int         BYTE_SH = $clog2(DATA_W / 8);
  localparam logic [2:0] LAT     = 3'(RD_LATENCY);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rd_en_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic              rd_err_q;
  logic [1:0]        resp_code_q;   // classification of the accepted address
  logic [2:0]        cnt_q;         // latency counter, counts WAIT cycles

  // ---------------------------------------------------------------------------
  // Address classification. It is evaluated on ARADDR and registered on the AR
  // handshake, so the DECODE cycle drives rd_en/rd_idx straight from flops.
  // The registered result is the latched copy of the address, and later ARADDR
  // changes do not affect it. The offset is only formed inside the window, so
  // the subtraction never wraps.
  // ---------------------------------------------------------------------------
  logic              in_win;
  logic              unaligned;
  logic              idx_ok;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] idx_full;
  logic [1:0]        dec_resp;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    in_win    = (ARADDR >= C_BASEADDR) && (ARADDR <= C_HIGHADDR);
    offset    = in_win ? (ARADDR - C_BASEADDR) : '0;
    idx_full  = offset >> BYTE_SH;
    unaligned = |offset[BYTE_SH-1:0];
    idx_ok    = idx_full < ADDR_W'(NUM_REGS);
    if (!in_win) begin
      dec_resp = RESP_DECERR;
    end else if (unaligned || !idx_ok) begin
      dec_resp = RESP_SLVERR;
    end else begin
      dec_resp = RESP_OKAY;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, and the order of the processes does not matter.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ARVALID && arready_q) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (resp_code_q != RESP_OKAY || RD_LATENCY == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT) state_d = S_RESP;
      end
      S_RESP: begin
        if (RREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel datapath and handshake flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rd_en_q     <= 1'b0;
      rd_idx_q    <= '0;
      rd_err_q    <= 1'b0;
      resp_code_q <= RESP_OKAY;
      cnt_q       <= '0;
    end else begin
      // Both strobes are single-cycle pulses.
      rd_en_q  <= 1'b0;
      rd_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ARVALID && arready_q) begin
            arready_q   <= 1'b0;
            resp_code_q <= dec_resp;
            if (dec_resp == RESP_OKAY) begin
              rd_en_q  <= 1'b1;
              rd_idx_q <= idx_full[IDX_W-1:0];
            end
          end else begin
            // Raises ARREADY on the first edge after reset is released.
            arready_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (resp_code_q != RESP_OKAY) begin
            rvalid_q <= 1'b1;
            rresp_q  <= resp_code_q;
            rdata_q  <= '0;
            rd_err_q <= 1'b1;
          end else if (RD_LATENCY == 0) begin
            // At zero latency the data is valid during the rd_en cycle.
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= rd_data;
          end else begin
            cnt_q <= 3'd1;
          end
        end
        S_WAIT: begin
          if (cnt_q == LAT) begin
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= rd_data;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_RESP: begin
          // RDATA/RRESP are not touched here, so they stay stable while stalled.
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign rd_en   = rd_en_q;
  assign rd_idx  = rd_idx_q;
  assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_adc_axil_read_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adc_axil_read_ctrl
//
// Two instances share one AR/R stimulus: u_dut0 (RD_LATENCY=0) and u_dut3
// (RD_LATENCY=3). Directed reads cover reset, latency, error decoding,
// back-pressure and reset in the middle of a read. A random phase then checks
// every response against a small address/register model.
// -----------------------------------------------------------------------------
module tb_adc_axil_read_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        RREADY;

  logic        arready0, rvalid0, rd_en0, rd_err0;
  logic [31:0] rdata0, rd_data0, rd_data0_man;
  logic [1:0]  rresp0;
  logic [2:0]  rd_idx0;

  logic        arready3, rvalid3, rd_en3, rd_err3;
  logic [31:0] rdata3, rd_data3, rd_data3_man;
  logic [1:0]  rresp3;
  logic [2:0]  rd_idx3;

  logic rnd_mode = 1'b0;
  int   epoch    = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int ok_exp   = 0;
  int en_cnt0  = 0;
  int en_cnt3  = 0;

  always #5 ACLK = ~ACLK;

  // Register file model for the random phase: the value depends on the index
  // and on the current read, so stale or wrongly indexed data is detectable.
  function automatic logic [31:0] reg_val(input logic [2:0] idx, input int ep);
    logic [7:0] e;
    e = ep[7:0];
    return {8'hC3, e, 13'h0, idx};
  endfunction

  assign rd_data0 = rnd_mode ? reg_val(rd_idx0, epoch) : rd_data0_man;
  assign rd_data3 = rnd_mode ? reg_val(rd_idx3, epoch) : rd_data3_man;

  adc_axil_read_ctrl #(.RD_LATENCY(0)) u_dut0 (
    .ACLK(ACLK), .ARESET(ARESET), .ARADDR(ARADDR), .ARVALID(ARVALID),
    .ARREADY(arready0), .RDATA(rdata0), .RRESP(rresp0), .RVALID(rvalid0),
    .RREADY(RREADY), .rd_en(rd_en0), .rd_idx(rd_idx0), .rd_data(rd_data0),
    .rd_err(rd_err0)
  );

  adc_axil_read_ctrl #(.RD_LATENCY(3)) u_dut3 (
    .ACLK(ACLK), .ARESET(ARESET), .ARADDR(ARADDR), .ARVALID(ARVALID),
    .ARREADY(arready3), .RDATA(rdata3), .RRESP(rresp3), .RVALID(rvalid3),
    .RREADY(RREADY), .rd_en(rd_en3), .rd_idx(rd_idx3), .rd_data(rd_data3),
    .rd_err(rd_err3)
  );

  // rd_en is a one-cycle pulse, so it is seen at exactly one falling edge.
  always @(negedge ACLK) begin
    if (rd_en0 === 1'b1) en_cnt0++;
    if (rd_en3 === 1'b1) en_cnt3++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d0"}, {arready0, rvalid0, rdata0, rresp0, rd_en0, rd_idx0, rd_err0}, 64'h0);
    check({tag, "_d3"}, {arready3, rvalid3, rdata3, rresp3, rd_en3, rd_idx3, rd_err3}, 64'h0);
  endtask

  // Waits for both instances to be ready and performs a one-cycle AR handshake.
  // It returns at the falling edge of cycle T+1 (the DECODE cycle).
  task automatic issue_ar(input logic [31:0] addr);
    int n;
    n = 0;
    while (!(arready0 === 1'b1 && arready3 === 1'b1) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    check("ar_ready_timeout", {31'h0, arready0 & arready3}, 64'h1);
    ARADDR  = addr;
    ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    ARADDR  = ~addr;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(arready0 === 1'b1 && arready3 === 1'b1 && rvalid0 === 1'b0 && rvalid3 === 1'b0)
           && n < 30) begin
      @(negedge ACLK);
      n++;
    end
    check("idle_timeout", {63'h0, (n < 30)}, 64'h1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    logic        done0, done3, seen0, seen3, pre0, pre3, any_rv;
    int          cat;
    logic [2:0]  idx;
    logic [2:0]  err_idx;

    ARESET       = 1'b1;
    ARADDR       = '0;
    ARVALID      = 1'b0;
    RREADY       = 1'b0;
    rd_data0_man = '0;
    rd_data3_man = '0;

    // ---------------- Reset state and ARREADY rise ----------------
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    check("arready_after_reset", {arready0, arready3}, 64'h3);

    // ---------------- A: read 0x08, rd_data A5A5_0003 ----------------
    rd_data0_man = 32'hA5A5_0003;
    rd_data3_man = 32'hA5A5_0003;
    ok_exp++;
    issue_ar(32'h08);
    check("A_t1_rd_en_idx_d0", {arready0, rd_en0, rd_idx0}, {59'h0, 2'b01, 3'd2});
    check("A_t1_rd_en_idx_d3", {rd_en3, rd_idx3}, {60'h0, 1'b1, 3'd2});
    check("A_t1_no_rvalid", {rvalid0, rvalid3}, 64'h0);
    @(negedge ACLK);  // T+2
    check("A_t2_resp_d0", {rvalid0, rresp0, rdata0}, {29'h0, 1'b1, 2'b00, 32'hA5A5_0003});
    check("A_t2_rd_en_low", {rd_en0, rvalid3}, 64'h0);
    RREADY = 1'b1;
    @(negedge ACLK);  // T+3
    check("A_t3_done_d0", {rvalid0, arready0}, 64'h1);
    @(negedge ACLK);  // T+4
    check("A_t4_d3_wait", {63'h0, rvalid3}, 64'h0);
    @(negedge ACLK);  // T+5
    check("A_t5_resp_d3", {rvalid3, rresp3, rdata3}, {29'h0, 1'b1, 2'b00, 32'hA5A5_0003});
    wait_idle();

    // ---------------- B: latency 3, read 0x1C, late rd_data ----------------
    rd_data0_man = 32'h0000_0707;
    rd_data3_man = 32'hDEAD_BEEF;
    ok_exp++;
    issue_ar(32'h1C);
    check("B_t1_idx", {rd_en0, rd_idx0, rd_en3, rd_idx3}, {56'h0, 1'b1, 3'd7, 1'b1, 3'd7});
    @(negedge ACLK);  // T+2
    check("B_t2_resp_d0", {rvalid0, rresp0, rdata0}, {29'h0, 1'b1, 2'b00, 32'h0000_0707});
    @(negedge ACLK);  // T+3
    @(negedge ACLK);  // T+4
    check("B_t4_d3_no_rvalid", {63'h0, rvalid3}, 64'h0);
    rd_data3_man = 32'h5A5A_0007;
    @(negedge ACLK);  // T+5
    check("B_t5_resp_d3", {rvalid3, rresp3, rdata3}, {29'h0, 1'b1, 2'b00, 32'h5A5A_0007});
    check("B_t5_idx_held", {61'h0, rd_idx3}, 64'd7);
    wait_idle();

    // ---------------- C: error responses ----------------
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin addr = 32'h0000_0006; exp_resp = 2'b10; end
        1:       begin addr = 32'h0000_0020; exp_resp = 2'b10; end
        default: begin addr = 32'h0000_2000; exp_resp = 2'b11; end
      endcase
      issue_ar(addr);
      check($sformatf("C%0d_no_rd_en", k), {rd_en0, rd_en3}, 64'h0);
      @(negedge ACLK);  // T+2
      check($sformatf("C%0d_resp_d0", k), {rvalid0, rd_err0, rresp0, rdata0},
            {28'h0, 1'b1, 1'b1, exp_resp, 32'h0});
      check($sformatf("C%0d_resp_d3", k), {rvalid3, rd_err3, rresp3, rdata3},
            {28'h0, 1'b1, 1'b1, exp_resp, 32'h0});
      @(negedge ACLK);  // T+3
      err_idx = rd_idx0;
      check($sformatf("C%0d_after", k), {rvalid0, rd_err0, arready0, rvalid3, rd_err3, arready3, err_idx},
            {55'h0, 6'b001001, 3'd7});
    end
    wait_idle();

    // ---------------- D: RREADY low for 4 cycles during RESP ----------------
    RREADY       = 1'b0;
    rd_data0_man = 32'h0000_1234;
    rd_data3_man = 32'h0000_1234;
    ok_exp++;
    issue_ar(32'h04);
    repeat (4) @(negedge ACLK);  // T+5
    check("D_both_valid", {rvalid0, rvalid3}, 64'h3);
    rd_data0_man = 32'hFFFF_FFFF;
    rd_data3_man = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      check($sformatf("D_stall%0d_d3", k), {arready3, rvalid3, rresp3, rdata3},
            {28'h0, 1'b0, 1'b1, 2'b00, 32'h0000_1234});
      check($sformatf("D_stall%0d_d0", k), {arready0, rvalid0, rresp0, rdata0},
            {28'h0, 1'b0, 1'b1, 2'b00, 32'h0000_1234});
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    check("D_complete", {rvalid0, arready0, rvalid3, arready3}, 64'b0101);

    // ---------------- E: reset during WAIT ----------------
    RREADY       = 1'b0;
    rd_data0_man = 32'h0000_000C;
    rd_data3_man = 32'h0000_000C;
    ok_exp++;  // rd_en fires in the DECODE cycle, before the reset
    issue_ar(32'h0C);
    @(negedge ACLK);  // T+2: u_dut3 in WAIT, u_dut0 presenting RVALID
    check("E_pre_reset", {rvalid0, rvalid3}, 64'b10);
    ARESET = 1'b1;
    #1;
    check_reset_outputs("E_async_reset");
    repeat (3) @(negedge ACLK);
    check_reset_outputs("E_held_reset");
    ARESET = 1'b0;
    any_rv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      any_rv = any_rv | rvalid0 | rvalid3;
    end
    check("E_no_response", {63'h0, any_rv}, 64'h0);
    RREADY       = 1'b1;
    rd_data0_man = 32'hCAFE_0004;
    rd_data3_man = 32'hCAFE_0004;
    ok_exp++;
    issue_ar(32'h10);
    repeat (4) @(negedge ACLK);  // T+5
    check("E_post_read_d3", {rvalid3, rresp3, rdata3, rd_idx3},
          {26'h0, 1'b1, 2'b00, 32'hCAFE_0004, 3'd4});
    wait_idle();

    // ---------------- F: random reads, random RREADY ----------------
    rnd_mode = 1'b1;
    for (int n = 0; n < 100; n++) begin
      epoch = n;
      cat   = $urandom_range(0, 9);
      idx   = 3'($urandom_range(0, 7));
      if (cat < 6)       addr = {27'h0, idx, 2'b00};
      else if (cat == 6) addr = {27'h0, idx, 2'b00} + 32'($urandom_range(1, 3));
      else if (cat == 7) addr = 32'($urandom_range(8, 1023)) << 2;
      else if (cat == 8) addr = 32'h0000_1000 + 32'($urandom_range(0, 65535));
      else               addr = $urandom | 32'h8000_0000;

      if (addr > 32'h0000_0FFF) begin
        exp_resp = 2'b11;
        exp_data = '0;
      end else if (addr[1:0] != 2'b00 || (addr >> 2) >= 32'd8) begin
        exp_resp = 2'b10;
        exp_data = '0;
      end else begin
        exp_resp = 2'b00;
        exp_data = reg_val(addr[4:2], n);
        ok_exp++;
      end

      issue_ar(addr);
      done0 = 1'b0; done3 = 1'b0; seen0 = 1'b0; seen3 = 1'b0;
      for (int c = 0; c < 40 && !(done0 && done3); c++) begin
        pre0 = rvalid0;
        pre3 = rvalid3;
        if (pre0 && !seen0) begin
          check($sformatf("F%0d_d0", n), {rresp0, rdata0}, {30'h0, exp_resp, exp_data});
          seen0 = 1'b1;
        end
        if (pre3 && !seen3) begin
          check($sformatf("F%0d_d3", n), {rresp3, rdata3}, {30'h0, exp_resp, exp_data});
          seen3 = 1'b1;
        end
        RREADY = 1'($urandom_range(0, 1));
        @(negedge ACLK);
        if (pre0 && RREADY) done0 = 1'b1;
        if (pre3 && RREADY) done3 = 1'b1;
      end
      check($sformatf("F%0d_done", n), {62'h0, done0, done3}, 64'h3);
    end
    RREADY = 1'b0;
    repeat (2) @(negedge ACLK);

    check("rd_en_count_d0", 64'(en_cnt0), 64'(ok_exp));
    check("rd_en_count_d3", 64'(en_cnt3), 64'(ok_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
